// File: rtl/mag_accum_nbit_if.sv
// Handshake bundle for mag_accum_nbit: burst start, magnitude input stream
// and the registered burst result with its own valid/ready pair.
interface mag_accum_nbit_if #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 40,
  parameter int LEN_WIDTH = 8
);
  logic                 start;
  logic [LEN_WIDTH-1:0] len;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic                 out_ovf;
  logic                 busy;

  modport master (
    output start, len, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf, busy
  );

  modport slave (
    input  start, len, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sum, out_ovf, busy
  );
endinterface

// File: rtl/mag_accum_nbit.sv
// Saturating burst accumulator: sums len unsigned magnitudes into an ACC_WIDTH
// register and holds the result (plus sticky overflow) until it is taken.
module mag_accum_nbit #(
  parameter int WIDTH     = 32,
  parameter int ACC_WIDTH = 40,
  parameter int LEN_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mag_accum_nbit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 ovf_q, ovf_d;

  logic                 beat;
  logic                 lastBeat;
  logic [LEN_WIDTH-1:0] countInc;
  logic [ACC_WIDTH:0]   sumExt;

  assign beat     = (state_q == ACC) && bus.in_valid;
  assign countInc = count_q + LEN_WIDTH'(1);
  assign lastBeat = beat && (countInc == len_q);

  // One spare bit above the accumulator catches the carry that signals saturation.
  assign sumExt = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, bus.in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = (bus.len == '0) ? HOLD : ACC;
        end
      end
      ACC: begin
        if (lastBeat) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      ACC: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b1;
      end
      HOLD: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Result registers are only touched by start and accepted beats, so they
  // stay put through HOLD and keep the last result visible back in IDLE.
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && bus.start) begin
      acc_d   = '0;
      count_d = '0;
      len_d   = bus.len;
      ovf_d   = 1'b0;
    end else if (beat) begin
      count_d = countInc;
      if (sumExt[ACC_WIDTH]) begin
        acc_d = '1;
        ovf_d = 1'b1;
      end else begin
        acc_d = sumExt[ACC_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.out_sum = acc_q;
  assign bus.out_ovf = ovf_q;

  holdStable: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == HOLD && !bus.out_ready) |=>
      (state_q == HOLD && $stable(acc_q) && $stable(ovf_q)));

  lenStableInBurst: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ACC) |=> $stable(len_q));

endmodule

// File: doc/mag_accum_nbit.md
MAG_ACCUM_NBIT -- requirements
Module: mag_accum_nbit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, magnitude input width in bits.
REQ-002 SHALL provide parameter ACC_WIDTH, default 40, accumulator and sum width; legal only when ACC_WIDTH >= WIDTH.
REQ-003 SHALL provide parameter LEN_WIDTH, default 8, width of the sample-count field.
REQ-004 SHALL provide port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL provide port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-006 SHALL provide port start, input, 1, begins a burst; sampled in IDLE only.
REQ-007 SHALL provide port len, input, LEN_WIDTH, number of samples in the burst; captured with start.
REQ-008 SHALL provide port in_valid, input, 1, upstream magnitude valid.
REQ-009 SHALL provide port in_ready, output, 1, block accepts a magnitude this cycle.
REQ-010 SHALL provide port in_data, input, WIDTH, unsigned magnitude from the n-bit abs stage.
REQ-011 SHALL provide port out_valid, output, 1, burst result available.
REQ-012 SHALL provide port out_ready, input, 1, downstream accepts the result.
REQ-013 SHALL provide port out_sum, output, ACC_WIDTH, accumulated sum of magnitudes.
REQ-014 SHALL provide port out_ovf, output, 1, sticky saturation flag for the burst.
REQ-015 SHALL provide port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-016 SHALL implement the states IDLE, ACC and HOLD, each held in a register.
REQ-017 In IDLE with start=1 and len!=0, SHALL capture len, clear the accumulator, count and ovf, and enter ACC next cycle.
REQ-018 In IDLE with start=1 and len=0, SHALL clear the accumulator and ovf and enter HOLD directly, so out_sum=0.
REQ-019 SHALL ignore start in ACC and HOLD; captured len SHALL NOT change mid-burst.
REQ-020 SHALL drive in_ready=1 only in ACC; a beat is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-021 On each accepted beat, SHALL add zero-extended in_data to the accumulator and increment the count by 1.
REQ-022 If the unsaturated sum exceeds 2^ACC_WIDTH-1, SHALL clamp the accumulator to all-ones and set ovf, with ovf sticky until the next start.
REQ-023 When the accepted beat makes count equal len, SHALL enter HOLD on the same edge; in_ready SHALL be 0 the following cycle.
REQ-024 SHALL drive out_valid=1 exactly while in HOLD, with out_sum and out_ovf registered and stable throughout HOLD.
REQ-025 Latency: out_valid SHALL rise in the cycle immediately after the last beat is accepted.
REQ-026 In HOLD with out_ready=1, SHALL complete the handshake and return to IDLE next cycle; out_valid SHALL NOT be withdrawn before out_ready.
REQ-027 In ACC, in_valid=0 cycles SHALL stall the block with no change to the accumulator or count.
REQ-028 SHALL retain out_sum and out_ovf after returning to IDLE, until the next start.
REQ-029 A start asserted on the same cycle as the out_ready handshake SHALL be ignored; start is sampled only in the IDLE cycle that follows.

Reset
REQ-030 While rst_n=0, SHALL force the state to IDLE, accumulator, count, captured len and ovf to 0, in_ready=0, out_valid=0, out_sum=0, out_ovf=0 and busy=0, regardless of clk.
REQ-031 Reset asserted mid-burst SHALL discard the partial sum; after release the block SHALL wait in IDLE for start.

Verification
REQ-032 Bench SHALL drive WIDTH=32 with start, len=3 and beats 5, 7, 0x10 back-to-back -> out_valid high the cycle after the third beat with out_sum=28 and out_ovf=0.
REQ-033 Bench SHALL drive len=4 with in_valid toggling 1,0,1,0,1,1 on beats of 1 -> exactly 4 beats accepted and out_sum=4.
REQ-034 Bench SHALL set ACC_WIDTH=32 with len=2 and beats 0xFFFFFFFF and 0x00000002 -> out_sum=0xFFFFFFFF and out_ovf=1.
REQ-035 Bench SHALL hold out_ready=0 for 5 cycles in HOLD -> out_valid and out_sum stable for all 5 cycles, with IDLE reached the cycle after out_ready=1.
REQ-036 Bench SHALL drive start with len=0 -> HOLD next cycle with out_sum=0 and in_ready never 1.
REQ-037 Bench SHALL drive rst_n=0 asynchronously after 2 of 3 beats -> all outputs 0 immediately, and a fresh len=1 burst with beat 9 gives out_sum=9.
